dmem_hold_gen: RTL and testbench
================================

# dmem_hold_gen

Data-memory access sequencer that produces the pipeline `hold` request consumed by the pipeline control unit. It sits between the EX/MEM-stage load/store request and a wait-stated data-memory bus with request/grant and response-valid handshakes. While a bus transaction is outstanding it freezes the pipeline through `hold_o`, which drives the control unit's `hold` input. It releases the hold for exactly one cycle when read data or a store acknowledge returns, or when the access times out.

## Interface
- `TIMEOUT`, default 255: cycles spent in REQ+WAIT before the access is abandoned; legal range 2..65535.
- `clk_100MHz`  in  1  system clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `mem_req_i`  in  1  load/store present in the memory stage; stable while `hold_o`=1.
- `mem_we_i`  in  1  1=store, 0=load.
- `mem_addr_i`  in  `MEM_ADDR`  byte address.
- `mem_wdata_i`  in  32  store data.
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  registered copy of `mem_we_i`.
- `bus_addr_o`  out  `MEM_ADDR`  registered address.
- `bus_wdata_o`  out  32  registered store data.
- `bus_gnt_i`  in  1  request accepted this cycle.
- `bus_rvalid_i`  in  1  response (read data or store ack).
- `bus_rdata_i`  in  32  read data, valid with `bus_rvalid_i`.
- `hold_o`  out  1  pipeline hold request, to the control unit's `hold`.
- `rdata_o`  out  32  load result, valid when `rdata_valid_o`=1.
- `rdata_valid_o`  out  1  one-cycle completion strobe.
- `err_o`  out  1  timeout flag, qualified by `rdata_valid_o`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE: when `mem_req_i`=1, capture `mem_we_i`, `mem_addr_i` and `mem_wdata_i`, clear the timeout counter, and go to REQ.
- REQ: `bus_req_o`=1.
  - `bus_gnt_i`=1 with `bus_rvalid_i`=1 goes to DONE.
  - `bus_gnt_i`=1 alone goes to WAIT.
  - Otherwise stay in REQ.
- WAIT: `bus_rvalid_i`=1 goes to DONE.
- Response capture: on the transition into DONE, capture `bus_rdata_i` into `rdata_o` for a load; `rdata_o` is forced to 0 for a store. `err_o`=0.
- Timeout counter:
  - Increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT`-1 with no qualifying handshake, go to DONE with `rdata_o`=0 and `err_o`=1.
  - A handshake in the same cycle as the timeout wins, and `err_o`=0.
  - The counter saturates and never wraps.
- DONE: `rdata_valid_o`=1 and `hold_o`=0, so the pipeline advances at the next edge. `mem_req_i` is ignored in DONE because it still belongs to the completed access. Next state is IDLE unconditionally.
- `hold_o` = (IDLE & `mem_req_i`) | REQ | WAIT. The IDLE term is combinational so the stage freezes in the same cycle the request appears.
- A `bus_rvalid_i` seen in IDLE or REQ without a grant is ignored. A `bus_gnt_i` seen outside REQ is ignored.
- Asynchronous reset mid-transaction:
  - Return to IDLE immediately.
  - Clear all outputs.
  - Drop `bus_req_o` without completing the transaction.

## Timing
- Reset values:
  - `bus_req_o`, `bus_we_o`, `hold_o`, `rdata_valid_o` and `err_o` are 0.
  - `bus_addr_o`, `bus_wdata_o` and `rdata_o` are 0.
- Best case, request seen at cycle 0 in IDLE:
  - Cycle 0: IDLE, `hold_o`=1.
  - Cycle 1: REQ with `bus_gnt_i` and `bus_rvalid_i` both 1.
  - Cycle 2: DONE, `hold_o`=0, result valid.
  - Total hold is 2 cycles.
- Grant in cycle 1 and response in cycle 2: DONE in cycle 3, total hold 3 cycles.
- Bus outputs are registered. `bus_addr_o`, `bus_we_o` and `bus_wdata_o` are stable from REQ entry through DONE.
- Back-to-back accesses: a new `mem_req_i` is accepted in the IDLE cycle immediately after DONE.
- There is no ungated bubble between accesses beyond the DONE cycle.
- Worst-case hold is `TIMEOUT`+1 cycles.

## Structure
- FSM state encodings (2-bit localparams) go into `define.v` alongside `MEM_ADDR`.
- `TIMEOUT` stays a module parameter.
- Counter width is $clog2(`TIMEOUT`).
- One sub-module is natural: `sat_counter`, a parameterised width/limit up-counter with synchronous clear and a terminal-count output, reusable elsewhere.
- `hold_o` is ORed with other hold sources at the top level before it reaches the control unit.

## Test plan
- Load to 0x100; grant at cycle 1, `bus_rvalid_i` with 0xDEADBEEF at cycle 3 -> `hold_o` high in cycles 0-3. Cycle 4: `rdata_valid_o`=1, `rdata_o`=0xDEADBEEF, `err_o`=0.
- Store 0x12345678 to 0x204; grant and rvalid together in cycle 1 -> `bus_we_o`=1 and `bus_wdata_o`=0x12345678 in REQ. DONE in cycle 2 with `rdata_o`=0.
- `TIMEOUT`=4, grant never asserted -> `bus_req_o` high for 4 cycles. DONE with `err_o`=1, `rdata_o`=0, then `hold_o` drops.
- Two consecutive loads with immediate responses -> second IDLE→REQ occurs the cycle after the first DONE. `rdata_valid_o` pulses are exactly 1 cycle each; stray `mem_req_i` in DONE starts nothing.
- `arst_n` asserted in WAIT -> all outputs 0 asynchronously. A late `bus_rvalid_i` after reset release produces no `rdata_valid_o`.
- Spurious `bus_rvalid_i` in IDLE and during REQ without grant -> no state change, no capture.

Source files
------------

// File: rtl/dmem_hold_gen_pkg.sv
// Shared types for the data-memory hold sequencer: FSM encoding, address width,
// and the captured load/store command.
package dmem_hold_gen_pkg;

  localparam int MEM_ADDR = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic                we;
    logic [MEM_ADDR-1:0] addr;
    logic [31:0]         wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_hold_gen_if.sv
// Memory-stage request, wait-stated bus and pipeline hold signals of dmem_hold_gen.
// master = the sequencer side, slave = the pipeline/bus environment side.
interface dmem_hold_gen_if;
  import dmem_hold_gen_pkg::*;

  logic                mem_req_i;
  logic                mem_we_i;
  logic [MEM_ADDR-1:0] mem_addr_i;
  logic [31:0]         mem_wdata_i;
  logic                bus_req_o;
  logic                bus_we_o;
  logic [MEM_ADDR-1:0] bus_addr_o;
  logic [31:0]         bus_wdata_o;
  logic                bus_gnt_i;
  logic                bus_rvalid_i;
  logic [31:0]         bus_rdata_i;
  logic                hold_o;
  logic [31:0]         rdata_o;
  logic                rdata_valid_o;
  logic                err_o;

  modport master (
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output hold_o, rdata_o, rdata_valid_o, err_o
  );

  modport slave (
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  hold_o, rdata_o, rdata_valid_o, err_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; tc flags count == LIMIT and
// stops further increments so the value never wraps.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/dmem_hold_gen.sv
// Data-memory access sequencer: runs one request/grant/response bus transaction
// per load/store and holds the pipeline until it completes or times out.
module dmem_hold_gen
  import dmem_hold_gen_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk_100MHz,
  input  logic            arst_n,
  dmem_hold_gen_if.master mem_if
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e      state_q, state_d;
  mem_cmd_t    cmd_q;
  logic        bus_req_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        capture_cmd;
  logic        done_rsp;
  logic        timeout_hit;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT - 1)
  ) u_timeout_cnt (
    .clk   (clk_100MHz),
    .rst_n (arst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    capture_cmd = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    done_rsp    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.mem_req_i) begin
          capture_cmd = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_en = 1'b1;
        // A completing handshake beats a simultaneous timeout.
        if (mem_if.bus_gnt_i && mem_if.bus_rvalid_i) begin
          done_rsp = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_tc) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end else if (mem_if.bus_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (mem_if.bus_rvalid_i) begin
          done_rsp = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_tc) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  // NOTE: async reset clears the command/response registers as well, so an
  // aborted access leaves nothing stale on the bus or the result outputs.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      bus_req_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= (state_d == ST_REQ);
      if (capture_cmd) begin
        cmd_q <= '{we:    mem_if.mem_we_i,
                   addr:  mem_if.mem_addr_i,
                   wdata: mem_if.mem_wdata_i};
      end
      if (done_rsp) begin
        rdata_q <= cmd_q.we ? 32'h0 : mem_if.bus_rdata_i;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem_if.bus_req_o     = bus_req_q;
  assign mem_if.bus_we_o      = cmd_q.we;
  assign mem_if.bus_addr_o    = cmd_q.addr;
  assign mem_if.bus_wdata_o   = cmd_q.wdata;
  assign mem_if.rdata_o       = rdata_q;
  assign mem_if.err_o         = err_q;
  assign mem_if.rdata_valid_o = (state_q == ST_DONE);

  // The IDLE term freezes the stage in the very cycle the request shows up;
  // reset gating keeps the hold low while the sequencer is held in reset.
  assign mem_if.hold_o = arst_n &
                         (((state_q == ST_IDLE) && mem_if.mem_req_i) ||
                          (state_q == ST_REQ) || (state_q == ST_WAIT));

endmodule

// File: tb/tb_dmem_hold_gen.sv
// Directed-vector bench for dmem_hold_gen (TIMEOUT=4): load with wait state,
// store, timeout, timeout-boundary handshake, back-to-back, reset abort, spurious bus.
module tb_dmem_hold_gen;

  logic clk_100MHz = 1'b0;
  logic arst_n     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  dmem_hold_gen_if mem_if ();

  dmem_hold_gen #(
    .TIMEOUT (4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .mem_if     (mem_if.master)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled well away from the edge.
  task automatic cyc();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    mem_if.bus_gnt_i    = gnt;
    mem_if.bus_rvalid_i = rvalid;
    mem_if.bus_rdata_i  = rdata;
  endtask

  task automatic set_mem(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    mem_if.mem_req_i   = req;
    mem_if.mem_we_i    = we;
    mem_if.mem_addr_i  = addr;
    mem_if.mem_wdata_i = wdata;
  endtask

  initial begin
    set_mem(1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);

    // Reset state
    #3;
    check("rst_hold",   {31'b0, mem_if.hold_o},        32'h0);
    check("rst_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    check("rst_bwe",    {31'b0, mem_if.bus_we_o},      32'h0);
    check("rst_baddr",  mem_if.bus_addr_o,             32'h0);
    check("rst_bwdata", mem_if.bus_wdata_o,            32'h0);
    check("rst_rdata",  mem_if.rdata_o,                32'h0);
    check("rst_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("rst_err",    {31'b0, mem_if.err_o},         32'h0);
    #9 arst_n = 1'b1;
    cyc();

    // Load to 0x100: grant at cycle 1, response 0xDEADBEEF at cycle 3
    set_mem(1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    check("ld_c0_hold", {31'b0, mem_if.hold_o},    32'h1);
    check("ld_c0_breq", {31'b0, mem_if.bus_req_o}, 32'h0);
    cyc();
    set_bus(1'b1, 1'b0, 32'h0);
    settle();
    check("ld_c1_breq",  {31'b0, mem_if.bus_req_o}, 32'h1);
    check("ld_c1_baddr", mem_if.bus_addr_o,         32'h100);
    check("ld_c1_bwe",   {31'b0, mem_if.bus_we_o},  32'h0);
    check("ld_c1_hold",  {31'b0, mem_if.hold_o},    32'h1);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("ld_c2_hold", {31'b0, mem_if.hold_o},    32'h1);
    check("ld_c2_breq", {31'b0, mem_if.bus_req_o}, 32'h0);
    cyc();
    set_bus(1'b0, 1'b1, 32'hDEADBEEF);
    settle();
    check("ld_c3_hold",   {31'b0, mem_if.hold_o},        32'h1);
    check("ld_c3_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("ld_c4_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("ld_c4_rdata",  mem_if.rdata_o,                32'hDEADBEEF);
    check("ld_c4_err",    {31'b0, mem_if.err_o},         32'h0);
    check("ld_c4_hold",   {31'b0, mem_if.hold_o},        32'h0);
    check("ld_c4_baddr",  mem_if.bus_addr_o,             32'h100);
    mem_if.mem_req_i = 1'b0;
    cyc();
    settle();
    check("ld_c5_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("ld_c5_hold",   {31'b0, mem_if.hold_o},        32'h0);

    // Store 0x12345678 to 0x204: grant and rvalid together in cycle 1
    set_mem(1'b1, 1'b1, 32'h204, 32'h12345678);
    cyc();
    set_bus(1'b1, 1'b1, 32'hFFFFFFFF);
    settle();
    check("st_c1_breq",   {31'b0, mem_if.bus_req_o}, 32'h1);
    check("st_c1_bwe",    {31'b0, mem_if.bus_we_o},  32'h1);
    check("st_c1_bwdata", mem_if.bus_wdata_o,        32'h12345678);
    check("st_c1_baddr",  mem_if.bus_addr_o,         32'h204);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("st_c2_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("st_c2_rdata",  mem_if.rdata_o,                32'h0);
    check("st_c2_err",    {31'b0, mem_if.err_o},         32'h0);
    check("st_c2_hold",   {31'b0, mem_if.hold_o},        32'h0);
    check("st_c2_bwe",    {31'b0, mem_if.bus_we_o},      32'h1);
    mem_if.mem_req_i = 1'b0;
    cyc();

    // Timeout: grant never asserted, bus_req high for exactly 4 cycles
    set_mem(1'b1, 1'b0, 32'h300, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      settle();
      check($sformatf("to_c%0d_breq", c), {31'b0, mem_if.bus_req_o}, 32'h1);
      check($sformatf("to_c%0d_hold", c), {31'b0, mem_if.hold_o},    32'h1);
    end
    cyc();
    settle();
    check("to_done_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    check("to_done_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("to_done_err",    {31'b0, mem_if.err_o},         32'h1);
    check("to_done_rdata",  mem_if.rdata_o,                32'h0);
    check("to_done_hold",   {31'b0, mem_if.hold_o},        32'h0);
    mem_if.mem_req_i = 1'b0;
    cyc();
    settle();
    check("to_idle_hold",   {31'b0, mem_if.hold_o},        32'h0);
    check("to_idle_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);

    // Response in the same cycle the counter hits its limit: handshake wins
    set_mem(1'b1, 1'b0, 32'h310, 32'h0);
    cyc();
    set_bus(1'b1, 1'b0, 32'h0);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    cyc();
    cyc();
    set_bus(1'b0, 1'b1, 32'hCAFEF00D);
    settle();
    check("tb_c4_hold", {31'b0, mem_if.hold_o}, 32'h1);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("tb_done_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("tb_done_err",    {31'b0, mem_if.err_o},         32'h0);
    check("tb_done_rdata",  mem_if.rdata_o,                32'hCAFEF00D);
    mem_if.mem_req_i = 1'b0;
    cyc();

    // Back-to-back loads with immediate responses; mem_req stays high in DONE
    set_mem(1'b1, 1'b0, 32'h400, 32'h0);
    cyc();
    set_bus(1'b1, 1'b1, 32'h11111111);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("bb1_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("bb1_rdata",  mem_if.rdata_o,                32'h11111111);
    cyc();
    mem_if.mem_addr_i = 32'h404;
    settle();
    check("bb_idle_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("bb_idle_hold",   {31'b0, mem_if.hold_o},        32'h1);
    check("bb_idle_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    cyc();
    set_bus(1'b1, 1'b1, 32'h22222222);
    settle();
    check("bb2_req_breq",  {31'b0, mem_if.bus_req_o}, 32'h1);
    check("bb2_req_baddr", mem_if.bus_addr_o,         32'h404);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("bb2_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("bb2_rdata",  mem_if.rdata_o,                32'h22222222);
    check("bb2_hold",   {31'b0, mem_if.hold_o},        32'h0);
    cyc();
    mem_if.mem_req_i = 1'b0;
    settle();
    check("bb_stray_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    check("bb_stray_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("bb_stray_hold",   {31'b0, mem_if.hold_o},        32'h0);

    // Asynchronous reset while waiting for a store response
    set_mem(1'b1, 1'b1, 32'h500, 32'hA5A5A5A5);
    cyc();
    set_bus(1'b1, 1'b0, 32'h0);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("ar_wait_hold",  {31'b0, mem_if.hold_o},   32'h1);
    check("ar_wait_bwe",   {31'b0, mem_if.bus_we_o}, 32'h1);
    #1 arst_n = 1'b0;
    settle();
    check("ar_hold",   {31'b0, mem_if.hold_o},        32'h0);
    check("ar_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    check("ar_bwe",    {31'b0, mem_if.bus_we_o},      32'h0);
    check("ar_baddr",  mem_if.bus_addr_o,             32'h0);
    check("ar_bwdata", mem_if.bus_wdata_o,            32'h0);
    check("ar_rdata",  mem_if.rdata_o,                32'h0);
    check("ar_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("ar_err",    {31'b0, mem_if.err_o},         32'h0);
    mem_if.mem_req_i = 1'b0;
    @(posedge clk_100MHz);
    #3 arst_n = 1'b1;
    cyc();
    set_bus(1'b0, 1'b1, 32'h33333333);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("ar_late_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("ar_late_rdata",  mem_if.rdata_o,                32'h0);
    check("ar_late_hold",   {31'b0, mem_if.hold_o},        32'h0);

    // Spurious rvalid in IDLE and in REQ without grant
    set_bus(1'b0, 1'b1, 32'h99999999);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    settle();
    check("sp_idle_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("sp_idle_breq",   {31'b0, mem_if.bus_req_o},     32'h0);
    check("sp_idle_rdata",  mem_if.rdata_o,                32'h0);
    set_mem(1'b1, 1'b0, 32'h600, 32'h0);
    cyc();
    set_bus(1'b0, 1'b1, 32'h77777777);
    cyc();
    set_bus(1'b1, 1'b1, 32'h0000600D);
    settle();
    check("sp_req_breq",   {31'b0, mem_if.bus_req_o},     32'h1);
    check("sp_req_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h0);
    check("sp_req_rdata",  mem_if.rdata_o,                32'h0);
    cyc();
    set_bus(1'b0, 1'b0, 32'h0);
    mem_if.mem_req_i = 1'b0;
    settle();
    check("sp_done_rvalid", {31'b0, mem_if.rdata_valid_o}, 32'h1);
    check("sp_done_rdata",  mem_if.rdata_o,                32'h0000600D);
    check("sp_done_err",    {31'b0, mem_if.err_o},         32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
